// File: rtl/gates_pkg.sv
// Shared constants for the two-input gate truth-table sequencer: gate bit
// positions in the gate_z bus, FSM state encodings and the reference gate model.
package gates_pkg;

  localparam int unsigned GATE_AND  = 0;
  localparam int unsigned GATE_OR   = 1;
  localparam int unsigned GATE_NAND = 2;
  localparam int unsigned GATE_NOR  = 3;
  localparam int unsigned GATE_XOR  = 4;
  localparam int unsigned GATE_XNOR = 5;

  localparam int unsigned NUM_GATES = 6;
  localparam int unsigned NUM_STEPS = 4;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StApply  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StCheck  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  // Golden response of every gate for one A/B combination, in gate_z bit order.
  function automatic logic [NUM_GATES-1:0] gate_expect(input logic a, input logic b);
    logic [NUM_GATES-1:0] e;
    e            = '0;
    e[GATE_AND]  = a & b;
    e[GATE_OR]   = a | b;
    e[GATE_NAND] = ~(a & b);
    e[GATE_NOR]  = ~(a | b);
    e[GATE_XOR]  = a ^ b;
    e[GATE_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_tt_sequencer.sv
// Walks A/B through 00,01,10,11, waits SETTLE_CYCLES per combination, then
// compares the gate array outputs against the golden truth table.
module gate_tt_sequencer
  import gates_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic [5:0] gate_z,
  output logic [1:0] step_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask
);

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LastStep   = 2'(NUM_STEPS - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] mask_q, mask_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic [5:0] check_mask;
  logic       run_active;

  assign check_mask = mask_q | (gate_z ^ gate_expect(step_q[1], step_q[0]));
  assign run_active = (state_q == StApply) || (state_q == StSettle) || (state_q == StCheck);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    if (run_active && abort) begin
      // Abort wins over any CHECK update; the partial fail_mask is kept.
      state_d = StIdle;
      step_d  = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StApply;
            step_d  = '0;
            cnt_d   = '0;
            mask_d  = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
        StApply: begin
          state_d = StSettle;
          cnt_d   = '0;
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_d = StCheck;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StCheck: begin
          mask_d = check_mask;
          if (step_q != LastStep) begin
            state_d = StApply;
            step_d  = step_q + 2'd1;
          end else begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (check_mask == '0);
          end
        end
        default: begin
          state_d = StIdle;
          step_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Stimulus bits are taken straight from the step register.
  assign gate_a    = step_q[1];
  assign gate_b    = step_q[0];
  assign step_idx  = step_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;

endmodule

// File: doc/gate_tt_sequencer.md
GATE_TT_SEQUENCER -- requirements
Module: gate_tt_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles to wait after applying each input combination before sampling gate_z (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, single-cycle run request.
REQ-005 SHALL have port abort, input, 1, terminates a run in progress.
REQ-006 SHALL have port gate_a, output, 1, registered A stimulus to the gate array.
REQ-007 SHALL have port gate_b, output, 1, registered B stimulus to the gate array.
REQ-008 SHALL have port gate_z, input, 6, gate array outputs {XNOR,XOR,NOR,NAND,OR,AND} in bits [5:0], synchronous to clk.
REQ-009 SHALL have port step_idx, output, 2, current combination index; gate_a = step_idx[1], gate_b = step_idx[0].
REQ-010 SHALL have port busy, output, 1, high while a run is in progress.
REQ-011 SHALL have port done, output, 1, high after a completed run until the next start or reset.
REQ-012 SHALL have port pass, output, 1, done AND fail_mask == 0.
REQ-013 SHALL have port fail_mask, output, 6, sticky per-gate mismatch flags, same bit order as gate_z.

Function
REQ-014 SHALL implement the states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-015 SHALL leave IDLE or DONE for APPLY when start=1, clearing fail_mask, done, step_idx and the settle counter on that edge.
REQ-016 SHALL ignore start while in APPLY, SETTLE or CHECK.
REQ-017 SHALL spend exactly 1 cycle in APPLY, exactly SETTLE_CYCLES cycles in SETTLE, and exactly 1 cycle in CHECK per combination.
REQ-018 SHALL, in CHECK, compute expected = {~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b} from gate_a/gate_b and OR (gate_z XOR expected) into fail_mask on that edge.
REQ-019 SHALL, on leaving CHECK, go to APPLY with step_idx+1 if step_idx<3, else go to DONE with step_idx held at 3.
REQ-020 SHALL assert busy for exactly 4*(SETTLE_CYCLES+2) cycles per uninterrupted run, with done rising on the edge busy falls.
REQ-021 SHALL, on abort=1 in APPLY, SETTLE or CHECK, go to IDLE on the next edge: busy=0, done=0, gate_a=gate_b=0, step_idx=0, fail_mask holding its partial value.
REQ-022 SHALL give abort priority over a CHECK update in the same cycle: fail_mask is not updated.
REQ-023 SHALL ignore abort in IDLE and DONE.
REQ-024 SHALL give start priority over abort when both are high in IDLE or DONE.
REQ-025 SHALL hold gate_a, gate_b, step_idx, fail_mask, done and pass stable in DONE.
REQ-026 SHALL drive every output from a register, with pass registered alongside done.

Reset
REQ-027 SHALL give rst priority over start and abort.
REQ-028 SHALL, on rst=1 at any clk edge, enter IDLE with gate_a=0, gate_b=0, step_idx=0, busy=0, done=0, pass=0, fail_mask=0, settle counter=0, including mid-run.

Structure
REQ-029 SHALL take state encodings and gate bit-index constants (GATE_AND=0, GATE_OR=1, GATE_NAND=2, GATE_NOR=3, GATE_XOR=4, GATE_XNOR=5) from shared package gates_pkg.
REQ-030 SHALL size the settle counter at 8 bits.
REQ-031 SHALL contain no sub-module; the testbench connects gate_a/gate_b/gate_z to an instance of BasicLogicGates, or to a fault-injecting model.

Verification
REQ-032 SHALL cover: good gates, SETTLE_CYCLES=2, start pulse -> busy high 16 cycles, step_idx 0,1,2,3, done=1, pass=1, fail_mask=000000.
REQ-033 SHALL cover: model with AND output stuck-at-1 -> done=1, pass=0, fail_mask=000001.
REQ-034 SHALL cover: model with XOR and XNOR swapped -> fail_mask=110000, pass=0.
REQ-035 SHALL cover: abort during SETTLE of step_idx=2 -> next cycle IDLE, busy=0, done=0, gate_a=gate_b=0; a later start completes a full 16-cycle run.
REQ-036 SHALL cover: rst asserted in CHECK with a mismatch present -> all outputs 0 next cycle, fail_mask=0.
REQ-037 SHALL cover: start held high through a whole run, SETTLE_CYCLES=1 -> mid-run start ignored, 12 busy cycles, immediate restart from DONE with fail_mask cleared.
